// File: rtl/switch_toggle_bank.sv
// Multi-channel switch debouncer and LED toggler: each active-low switch is
// synchronised, debounced and edge-detected, then drives one LED in a selectable mode.
module switch_toggle_bank #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     i_Switch,
    input  logic [2*NUM_CH-1:0]   i_Mode,
    input  logic                  i_Clear,
    output logic [NUM_CH-1:0]     o_LED,
    output logic [NUM_CH-1:0]     o_Press,
    output logic [NUM_CH-1:0]     o_Release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_TOGGLE_PRESS   = 2'b00,
        MODE_MOMENTARY      = 2'b01,
        MODE_TOGGLE_RELEASE = 2'b10,
        MODE_TOGGLE_BOTH    = 2'b11
    } mode_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic          sync1;
        logic          s;
        logic          d;
        logic [CW-1:0] cnt;
        logic          accept;
        logic          led_q;
        logic          led_next;
        logic          press_q;
        logic          release_q;
        mode_e         mode;

        assign mode   = mode_e'(i_Mode[2*c +: 2]);
        // An event is accepted on the last cycle of an unbroken run of s != d.
        assign accept = (s != d) && (cnt == CNT_LAST);

        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        always_comb begin
            led_next = led_q;
            case (mode)
                MODE_TOGGLE_PRESS:   if (accept && !s) led_next = ~led_q;
                MODE_MOMENTARY:      led_next = ~d;
                MODE_TOGGLE_RELEASE: if (accept && s)  led_next = ~led_q;
                MODE_TOGGLE_BOTH:    if (accept)       led_next = ~led_q;
                default:             led_next = led_q;
            endcase
            if (i_Clear) begin
                led_next = 1'b0;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of its neighbours.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1     <= 1'b1;
                s         <= 1'b1;
                d         <= 1'b1;
                cnt       <= '0;
                led_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1     <= i_Switch[c];
                s         <= sync1;
                press_q   <= accept && !s;
                release_q <= accept && s;
                led_q     <= led_next;
                if (s == d) begin
                    cnt <= '0;
                end else if (accept) begin
                    d   <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign o_LED[c]     = led_q;
        assign o_Press[c]   = press_q;
        assign o_Release[c] = release_q;
    end

endmodule

// File: doc/switch_toggle_bank.md
# switch_toggle_bank

Multi-channel successor to the single-switch LED toggler: NUM_CH active-low push-switches are synchronised, debounced and edge-detected, and each drives one LED register in a per-channel selectable mode (toggle-on-press, momentary, toggle-on-release, toggle-on-both). It sits between the board switch pins and the LED pins of the DE0 top level and also exports single-cycle press/release pulses for other logic.

## Interface
- NUM_CH, 4, number of independent switch/LED channels (≥1)
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new switch level (5 ms at 50 MHz); ≥1
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset; one clock, reset is asynchronous and active-high
- i_Switch  input  NUM_CH  raw switch levels, asynchronous, 0 = pressed
- i_Mode  input  2*NUM_CH  per-channel mode, bits [2c+1:2c] for channel c; quasi-static
- i_Clear  input  1  synchronous clear of all LED registers
- o_LED  output  NUM_CH  LED drive, 1 = on
- o_Press  output  NUM_CH  one-cycle pulse on accepted press (debounced 1→0)
- o_Release  output  NUM_CH  one-cycle pulse on accepted release (debounced 0→1)

## Operation
- Per channel: 2-FF synchroniser (sync1, sync2 = s), debounced level d, counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
- Reset values: sync1=s=1, d=1 (released), cnt=0, o_LED=0, o_Press=0, o_Release=0.
- Debounce, each clock: if s==d, cnt<=0. If s!=d and cnt==DEBOUNCE_CYCLES-1: d<=s, cnt<=0, accept event. Else cnt<=cnt+1. Any return of s to d before acceptance restarts the count (glitches shorter than DEBOUNCE_CYCLES cycles are ignored).
- Accepted event sets o_Press (s==0) or o_Release (s==1) for exactly that one cycle; otherwise both pulses 0.
- Modes, LED update per channel:
  - 00 toggle-on-press: o_LED inverts on accepted press.
  - 01 momentary: o_LED <= ~d every cycle (LED lit while debounced-pressed, one-cycle lag behind d).
  - 10 toggle-on-release: o_LED inverts on accepted release.
  - 11 toggle-on-both: o_LED inverts on either accepted event.
- i_Clear high: all o_LED <= 0 that cycle, overriding any toggle or momentary load in the same cycle. Does not affect debounce state or pulses.
- Mode change: o_LED holds its value in toggle modes; entering mode 01 loads ~d on the next clock. No event is generated by a mode change.
- Channels fully independent; simultaneous events on several channels are all honoured in the same cycle.
- rst asserted mid-count or mid-press: all state returns to reset values immediately; a switch still held low after release of rst is re-accepted as a new press after debounce.

## Timing
- i_Switch change set up before edge k: sync1 at k, s at k+1, d/o_Press/o_Release/toggled o_LED at edge k+1+DEBOUNCE_CYCLES, provided i_Switch stays stable.
- Momentary LED updates at edge k+2+DEBOUNCE_CYCLES.
- Pulses high for exactly one cycle; minimum spacing between accepted events on a channel is DEBOUNCE_CYCLES cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Use NUM_CH=4, DEBOUNCE_CYCLES=4. Reset, all switches 1 -> o_LED=0000, no pulses; hold 20 cycles, still 0000.
- Ch0 mode 00, drive i_Switch[0]=0 before edge k and hold -> o_Press[0]=1 only at edge k+5, o_LED[0]=1 from k+5; release and re-press after debounce -> o_Release[0] pulse, o_LED[0]=1 unchanged, then 0 on second press.
- Ch1 glitch: i_Switch[1]=0 for 3 cycles then 1 -> no pulses, o_LED[1] unchanged; 4-cycle-plus low -> accepted.
- Ch2 mode 01 press 10 cycles -> o_LED[2]=1 from k+6 until 6 cycles after release edge; ch3 mode 11 press+release -> o_LED[3] 0→1→0.
- All four channels pressed same cycle, modes 00 -> o_Press=1111 on one cycle, o_LED=1111; i_Clear coincident with a second accepted press -> o_LED=0000.
- Assert rst while ch0 cnt=2 and o_LED=1111 -> outputs 0000 immediately (asynchronously); deassert with i_Switch[0] held 0 -> o_Press[0] pulse 5 cycles after first post-reset edge.
